axi_cnt_bridge: RTL

AXI_CNT_BRIDGE -- requirements
Module: axi_cnt_bridge

---
 rtl/axi_cnt_bridge.sv | 126 ++++++++++++
 1 files changed

// File: rtl/axi_cnt_bridge.sv
// axi_cnt_bridge: AXI4-Lite slave that forwards reads to per-channel external counters,
// with a per-channel timeout and a W1C sticky timeout STATUS register.
module axi_cnt_bridge #(
  parameter int NCH      = 4,
  parameter int CH_SHIFT = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_awvalid,
  output logic              io_in_awready,
  input  logic [31:0]       io_in_awaddr,
  input  logic              io_in_wvalid,
  output logic              io_in_wready,
  input  logic [31:0]       io_in_wdata,
  input  logic [3:0]        io_in_wstrb,
  output logic              io_in_bvalid,
  input  logic              io_in_bready,
  output logic [1:0]        io_in_bresp,
  input  logic              io_in_arvalid,
  output logic              io_in_arready,
  input  logic [31:0]       io_in_araddr,
  output logic              io_in_rvalid,
  input  logic              io_in_rready,
  output logic [31:0]       io_in_rdata,
  output logic [1:0]        io_in_rresp,
  output logic [NCH-1:0]    ext_req,
  output logic [NCH*32-1:0] ext_addr,
  input  logic [NCH*32-1:0] ext_data,
  input  logic [NCH-1:0]    ext_ack
);
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  localparam logic [31:0] OFF_MASK = (32'h1 << CH_SHIFT) - 32'h1;
  typedef enum logic [1:0] {IDLE, EXT_WAIT, RRESP, BRESP} state_t;
  state_t            r_state;
  logic [CW-1:0]     r_ch;
  logic [15:0]       r_cnt;
  logic [NCH-1:0]    r_to;
  logic [NCH-1:0]    r_ext_req;
  logic [NCH*32-1:0] r_ext_addr;
  logic [31:0]       r_rdata;
  logic [1:0]        r_rresp;
  logic [1:0]        r_bresp;
  logic              w_idle;
  logic              w_ar;
  logic              w_aw;
  logic [CW-1:0]     w_ch;
  logic [31:0]       w_hi;
  logic              w_bad;
  logic              w_ack;
  logic              w_tmo;
  logic              w_unused;
  assign w_idle   = r_state == IDLE;
  // ready is masked by reset so it is low during reset yet usable on the first edge after
  assign io_in_arready = w_idle & ~reset;
  assign io_in_awready = w_idle & ~reset & io_in_awvalid & io_in_wvalid & ~io_in_arvalid;
  assign io_in_wready  = io_in_awready;
  assign io_in_rvalid  = r_state == RRESP;
  assign io_in_bvalid  = r_state == BRESP;
  assign io_in_rdata   = r_rdata;
  assign io_in_rresp   = r_rresp;
  assign io_in_bresp   = r_bresp;
  assign ext_req  = r_ext_req;
  assign ext_addr = r_ext_addr;
  assign w_ar  = io_in_arvalid & io_in_arready;
  assign w_aw  = io_in_awvalid & io_in_awready;
  assign w_ch  = io_in_araddr[CH_SHIFT +: CW];
  assign w_hi  = {1'b0, io_in_araddr[30:0]} >> (CH_SHIFT + CW);
  assign w_bad = (w_hi != 32'h0) || (32'(w_ch) >= 32'(NCH));
  assign w_ack = ext_ack[r_ch];
  assign w_tmo = r_cnt == 16'(TIMEOUT - 1);
  assign w_unused = ^{io_in_awaddr[30:0], io_in_wstrb[3:1], io_in_wdata};
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state    <= IDLE;
      r_ch       <= '0;
      r_cnt      <= '0;
      r_to       <= '0;
      r_ext_req  <= '0;
      r_ext_addr <= '0;
      r_rdata    <= '0;
      r_rresp    <= '0;
      r_bresp    <= '0;
    end else begin
      case (r_state)
        IDLE:
          if (w_ar) begin
            if (io_in_araddr[31]) begin
              r_rdata <= 32'(r_to);
              r_rresp <= 2'b00;
              r_state <= RRESP;
            end else if (w_bad) begin
              r_rdata <= '0;
              r_rresp <= 2'b11;
              r_state <= RRESP;
            end else begin
              r_ch                        <= w_ch;
              r_ext_req[w_ch]             <= 1'b1;
              r_ext_addr[32*w_ch +: 32]   <= io_in_araddr & OFF_MASK;
              r_cnt                       <= '0;
              r_state                     <= EXT_WAIT;
            end
          end else if (w_aw) begin
            r_bresp <= io_in_awaddr[31] ? 2'b00 : 2'b10;
            if (io_in_awaddr[31] && io_in_wstrb[0]) r_to <= r_to & ~io_in_wdata[NCH-1:0];
            r_state <= BRESP;
          end
        // an ack in the final counted cycle is tested first, so it beats the timeout
        EXT_WAIT:
          if (w_ack) begin
            r_rdata   <= ext_data[32*r_ch +: 32];
            r_rresp   <= 2'b00;
            r_ext_req <= '0;
            r_state   <= RRESP;
          end else if (w_tmo) begin
            r_rdata    <= '0;
            r_rresp    <= 2'b10;
            r_ext_req  <= '0;
            r_to[r_ch] <= 1'b1;
            r_state    <= RRESP;
          end else r_cnt <= r_cnt + 16'h1;
        RRESP: if (io_in_rready) r_state <= IDLE;
        BRESP: if (io_in_bready) r_state <= IDLE;
      endcase
    end
endmodule
